zx_kbd_remote: RTL
==================

# zx_kbd_remote

Remote keyboard matrix for the ZX81 core, directly downstream of the serial peripheral's register 08 (`kb_strobe`/`press`/`row`/`col`). Each strobe rising edge is one host event that sets or clears one key in a 8×5 key matrix. The block answers ULA/CPU keyboard reads by row-selecting that matrix and merging it with the physical keyboard, so serial-injected keys look exactly like real key presses.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2500000: auto-release timeout in clock cycles (50 ms at 50 MHz). Used only with `ZX_KBD_AUTORELEASE_EN`. Must be ≥ 2.
- `CNT_W`, default 22: auto-release counter width. Must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- `clock`  in  1: system clock, 50 MHz, single clock domain.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `kb_strobe`  in  1: event strobe from the serial peripheral; a rising edge marks one event.
- `press`  in  1: 1 = press, 0 = release.
- `row`  in  3: key row 0–7.
- `col`  in  3: key column 0–4. Value 7 is the all-keys command. Values 5–6 are ignored.
- `cpu_addr_hi`  in  8: CPU A15..A8. An active-low bit r selects row r.
- `phys_cols_n`  in  5: physical keyboard columns, active-low.
- `kbd_cols_n`  out  5: merged keyboard data for D4..D0, active-low, registered.
- `any_key`  out  1: 1 while any remote key is held, registered.
- `event_cnt`  out  8: count of accepted events, wraps 255→0.
- `autorel_pulse`  out  1: one-cycle pulse when auto-release clears the matrix. Tied 0 without the macro.

## Operation
- Internal state: 40-bit `matrix[row][col]`, 1 = remote key held.
- Edge detect: `strobe_d` is a register of `kb_strobe`. An event is accepted on the edge where `kb_strobe`=1 and `strobe_d`=0. `press`, `row` and `col` are sampled on that same edge.
- Event decode:
  - `col` 0–4: `matrix[row][col]` ← `press`.
  - `col`=7 and `press`=0: clear the whole matrix, any `row` value.
  - `col`=7 and `press`=1, or `col` 5–6: no matrix change. The event still increments `event_cnt`.
- Every accepted event increments `event_cnt` by 1, modulo 256.
- Column output, for each c:
  - `kbd_cols_n[c]` ← `phys_cols_n[c]` AND NOT( OR over r of ( `cpu_addr_hi[r]`=0 AND `matrix[r][c]` ) ).
  - With no row selected (`cpu_addr_hi`=FF), the output equals `phys_cols_n`.
  - With several rows selected, the selected rows are ORed.
- `any_key` ← (`matrix` ≠ 0).
- Auto-release (macro only). Two states:
  - IDLE → ARMED on a press event on col 0–4. The counter loads HOLD_CYCLES−1.
  - In ARMED, the counter decrements by 1 per cycle.
  - ARMED: each further press event reloads the counter. Release events do not reload it.
  - ARMED → IDLE when the matrix becomes 0 through events.
  - ARMED with counter=0: clear the matrix, pulse `autorel_pulse`, go to IDLE.
  - Simultaneous event and expiry: the event wins. It is applied, the counter reloads (press) or the state follows the matrix (release), and no auto-clear happens.
- Reset values:
  - `matrix`=0, `strobe_d`=1, so a strobe held high through reset is not an event.
  - `kbd_cols_n`=5'b11111, `any_key`=0, `event_cnt`=0, `autorel_pulse`=0.
  - Auto-release state IDLE, counter 0.
- Reset asserted mid-operation clears everything asynchronously. The first event after reset release needs a fresh rising edge.

## Timing
- Accepted event at edge E: `matrix` and `event_cnt` update at E. `kbd_cols_n` and `any_key` reflect the change at E+1.
- `cpu_addr_hi` or `phys_cols_n` change: `kbd_cols_n` follows one edge later. This gives 20 ns latency, well inside a 3.25 MHz CPU IN cycle.
- Events closer than 2 cycles apart are not required to be supported. Serial byte rate guarantees much larger spacing.
- Auto-release: press accepted at E; with no further press, the clear happens at E+HOLD_CYCLES and `autorel_pulse` is high for the cycle after that edge.

## Configuration
- `ZX_KBD_AUTORELEASE_EN` defined: the counter, the IDLE/ARMED machine and `autorel_pulse` are built. Stuck keys from a lost serial release byte clear after HOLD_CYCLES.
- `ZX_KBD_AUTORELEASE_EN` undefined: keys stay held until an explicit release or the all-keys command. `autorel_pulse` is constant 0 and the counter logic is absent.

## Structure
- Shared package `zx_kbd_pkg`:
  - constants `KBD_ROWS`=8, `KBD_COLS`=5, `KBD_COL_ALL`=3'd7;
  - the matrix typedef, 8 rows × 5 bits.
- Sub-module `zx_kbd_colmux`: combinational row-select/merge of matrix, `cpu_addr_hi` and `phys_cols_n` into the next value of `kbd_cols_n`. The top block registers its output.

## Test plan
- Reset release with `kb_strobe`=1 held → `event_cnt`=0, matrix 0, `kbd_cols_n`=1F.
- Strobe row=2 col=3 press=1, then `cpu_addr_hi`=FB → `kbd_cols_n`=17 one edge later. With `cpu_addr_hi`=FF → 1F. `any_key`=1, `event_cnt`=1.
- Press r0c0 and r7c4, `cpu_addr_hi`=7E → `kbd_cols_n`=0E. Then col=7 press=0 → 1F, `any_key`=0.
- Press r1c1, `phys_cols_n`=1E, `cpu_addr_hi`=FD → `kbd_cols_n`=1C. Then col=5 press=1 → `event_cnt`+1, matrix unchanged.
- With macro and HOLD_CYCLES=8: press r0c0 at E → clear and `autorel_pulse` at E+8. A re-press at E+4 moves the clear to E+12. An event exactly on the expiry edge suppresses the clear.
- 256 events → `event_cnt` wraps to 0. Reset asserted between strobe edges → outputs return to reset values immediately.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
// Shared definitions for the ZX81 remote keyboard matrix: geometry, the
// matrix type and the auto-release state encoding.
package zx_kbd_pkg;

  localparam int         KBD_ROWS    = 8;
  localparam int         KBD_COLS    = 5;
  localparam logic [2:0] KBD_COL_ALL = 3'd7;

  // matrix[r][c] = 1 while remote key (row r, column c) is held
  typedef logic [KBD_ROWS-1:0][KBD_COLS-1:0] kbd_matrix_t;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ARMED = 1'b1
  } ar_state_e;

endpackage

// File: rtl/zx_kbd_remote_if.sv
// Signal bundle between the serial peripheral / ULA side (master) and the
// remote keyboard block (slave).
interface zx_kbd_remote_if;
  import zx_kbd_pkg::*;

  // Handshake: there is no ready. Each 0->1 transition of kb_strobe is one
  // event; press/row/col must be stable on the clock edge where kb_strobe is
  // first seen high, and kb_strobe must be seen low for at least one edge
  // before the next event.
  logic                kb_strobe;
  logic                press;
  logic [2:0]          row;
  logic [2:0]          col;
  logic [7:0]          cpu_addr_hi;
  logic [KBD_COLS-1:0] phys_cols_n;
  logic [KBD_COLS-1:0] kbd_cols_n;
  logic                any_key;
  logic [7:0]          event_cnt;
  logic                autorel_pulse;
  ar_state_e           ar_state;

  modport master (
    output kb_strobe, press, row, col, cpu_addr_hi, phys_cols_n,
    input  kbd_cols_n, any_key, event_cnt, autorel_pulse, ar_state
  );

  modport slave (
    input  kb_strobe, press, row, col, cpu_addr_hi, phys_cols_n,
    output kbd_cols_n, any_key, event_cnt, autorel_pulse, ar_state
  );

endinterface

// File: rtl/zx_kbd_colmux.sv
// Row-select of the remote matrix by the active-low CPU address byte, merged
// (wired-AND, active-low) with the physical keyboard columns.
module zx_kbd_colmux
  import zx_kbd_pkg::*;
(
  input  kbd_matrix_t         matrix,
  input  logic [7:0]          cpu_addr_hi,
  input  logic [KBD_COLS-1:0] phys_cols_n,
  output logic [KBD_COLS-1:0] cols_n_next
);

  logic [KBD_COLS-1:0] hit;

  always_comb begin
    hit = '0;
    for (int r = 0; r < KBD_ROWS; r++) begin
      if (!cpu_addr_hi[r]) hit = hit | matrix[r];
    end
    cols_n_next = phys_cols_n & ~hit;
  end

endmodule

// File: rtl/zx_kbd_remote.sv
// Remote keyboard matrix fed by serial strobe events, merged into ULA reads.
// Optional stuck-key auto-release is built when ZX_KBD_AUTORELEASE_EN is defined.
module zx_kbd_remote
  import zx_kbd_pkg::*;
#(
  parameter int HOLD_CYCLES = 2500000,
  parameter int CNT_W       = 22
) (
  input  logic            clock,
  input  logic            reset_n,
  zx_kbd_remote_if.slave  bus
);

  if (HOLD_CYCLES < 2 || longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("zx_kbd_remote: HOLD_CYCLES must be >= 2 and below 2**CNT_W");
  end

  logic                strobe_d;
  logic                ev;
  logic                col_ok;
  logic                auto_clear;
  kbd_matrix_t         matrix;
  kbd_matrix_t         matrix_ev;
  kbd_matrix_t         matrix_next;
  logic [KBD_COLS-1:0] cols_next;

  assign ev     = bus.kb_strobe & ~strobe_d;
  assign col_ok = (bus.col < 3'(KBD_COLS));

  // Matrix after applying this cycle's event (if any), before auto-release
  always_comb begin
    matrix_ev = matrix;
    if (ev) begin
      if (col_ok) matrix_ev[bus.row][bus.col] = bus.press;
      else if (bus.col == KBD_COL_ALL && !bus.press) matrix_ev = '0;
    end
  end

  assign matrix_next = auto_clear ? '0 : matrix_ev;

  zx_kbd_colmux u_colmux (
    .matrix      (matrix),
    .cpu_addr_hi (bus.cpu_addr_hi),
    .phys_cols_n (bus.phys_cols_n),
    .cols_n_next (cols_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_d       <= 1'b1;
      matrix         <= '0;
      bus.kbd_cols_n <= '1;
      bus.any_key    <= 1'b0;
      bus.event_cnt  <= 8'd0;
    end else begin
      strobe_d       <= bus.kb_strobe;
      matrix         <= matrix_next;
      bus.kbd_cols_n <= cols_next;
      bus.any_key    <= |matrix;
      if (ev) bus.event_cnt <= bus.event_cnt + 8'd1;
    end
  end

`ifdef ZX_KBD_AUTORELEASE_EN
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  ar_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_dec;
  logic             press_ev;

  assign press_ev = ev & bus.press & col_ok;
  // Saturate so a non-press event landing on expiry leaves the count at 0
  assign cnt_dec  = (cnt == '0) ? '0 : cnt - CNT_W'(1);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    auto_clear = 1'b0;
    case (state)
      AR_IDLE: begin
        if (press_ev) begin
          state_next = AR_ARMED;
          cnt_next   = HOLD_LOAD;
        end
      end
      AR_ARMED: begin
        if (ev) begin
          cnt_next = press_ev ? HOLD_LOAD : cnt_dec;
          if (matrix_ev == '0) begin
            state_next = AR_IDLE;
            cnt_next   = '0;
          end
        end else if (cnt == '0) begin
          auto_clear = 1'b1;
          state_next = AR_IDLE;
        end else begin
          cnt_next = cnt_dec;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= AR_IDLE;
      cnt               <= '0;
      bus.autorel_pulse <= 1'b0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      bus.autorel_pulse <= auto_clear;
    end
  end

  assign bus.ar_state = state;
`else
  assign auto_clear        = 1'b0;
  assign bus.autorel_pulse = 1'b0;
  assign bus.ar_state      = AR_IDLE;
`endif

endmodule
